// File: rtl/abc_producer.sv
// Initiator end of the dav_/rfd four-phase operand handshake.
// Takes operand pairs from a local valid/ready port and returns the consumer's result.
module abc_producer #(
  parameter int unsigned W       = 4,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CW      = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  output logic          in_ready,
  output logic [W-1:0]  a,
  output logic [W-1:0]  b,
  output logic          dav_,
  input  logic          rfd,
  input  logic [W+1:0]  p,
  output logic          res_valid,
  output logic [W+1:0]  res_p,
  output logic          res_err,
  output logic          busy,
  output logic [CW-1:0] count
);

  localparam int unsigned TmoW = $clog2(TIMEOUT);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StDrive, StRelease} state_e;

  state_e          state_q, state_d;
  logic [TmoW-1:0] tmo_q;
  logic            transfer;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (transfer) state_d = StSetup;
      StSetup:   state_d = StDrive;
      StDrive:   if (!rfd || (tmo_q == TmoMax)) state_d = StRelease;
      StRelease: if (rfd) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready = (state_q == StIdle) && rfd;
    busy     = (state_q != StIdle);
    transfer = in_valid && in_ready;
  end

  // Handshake datapath; res_valid/res_err are single-cycle pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a         <= '0;
      b         <= '0;
      dav_      <= 1'b1;
      res_p     <= '0;
      res_valid <= 1'b0;
      res_err   <= 1'b0;
      count     <= '0;
      tmo_q     <= '0;
    end else begin
      res_valid <= 1'b0;
      res_err   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (transfer) begin
            a <= in_a;
            b <= in_b;
          end
        end
        StSetup: begin
          dav_  <= 1'b0;
          tmo_q <= '0;
        end
        StDrive: begin
          // Success takes priority over a coincident timeout.
          if (!rfd) begin
            res_p     <= p;
            res_valid <= 1'b1;
            count     <= count + 1'b1;
            dav_      <= 1'b1;
          end else if (tmo_q == TmoMax) begin
            res_valid <= 1'b1;
            res_err   <= 1'b1;
            dav_      <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_abc_producer.sv
// Self-checking bench for abc_producer: a transaction-level consumer model drives rfd/p
// and the expected result, count and timing are derived from the handshake rules.
`timescale 1ns/1ps
module tb_abc_producer;

  localparam int unsigned W       = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CW      = 2;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          dav_;
  logic          rfd;
  logic [W+1:0]  p;
  logic          res_valid;
  logic [W+1:0]  res_p;
  logic          res_err;
  logic          busy;
  logic [CW-1:0] count;

  int checks;
  int errors;
  int exp_count;
  logic [W+1:0] exp_res_p;

  abc_producer #(.W(W), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .dav_      (dav_),
    .rfd       (rfd),
    .p         (p),
    .res_valid (res_valid),
    .res_p     (res_p),
    .res_err   (res_err),
    .busy      (busy),
    .count     (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  // Consumer's computation: p = 2*(a+b).
  function automatic logic [W+1:0] consumer_result(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W+1:0] s;
    s = {2'b00, x} + {2'b00, y};
    return {s[W:0], 1'b0};
  endfunction

  function automatic logic [CW-1:0] exp_cnt();
    logic [31:0] c;
    c = exp_count;
    return c[CW-1:0];
  endfunction

  // One full successful handshake. delay = cycles rfd stays high after dav_ falls,
  // hold = cycles rfd stays low after dav_ rises.
  task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_, input int delay,
                         input int hold, input bit keep_valid, input logic [W-1:0] na,
                         input logic [W-1:0] nb, input string tag);
    logic [W+1:0] pv;
    in_valid = 1'b1;
    in_a     = ta;
    in_b     = tb_;
    rfd      = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_ready: in_ready=%b busy=%b want 1 0", tag, in_ready, busy);
    end
    tick;
    if (keep_valid) begin
      in_a = na;
      in_b = nb;
    end else begin
      in_valid = 1'b0;
    end
    checks++;
    if (dav_ !== 1'b1 || a !== ta || b !== tb_ || busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s setup: dav_=%b a=%0d b=%0d busy=%b rdy=%b want 1 %0d %0d 1 0",
               tag, dav_, a, b, busy, in_ready, ta, tb_);
    end
    tick;
    checks++;
    if (dav_ !== 1'b0 || a !== ta || b !== tb_) begin
      errors++;
      $display("FAIL %s dav_fall: dav_=%b a=%0d b=%0d want 0 %0d %0d", tag, dav_, a, b, ta, tb_);
    end
    for (int i = 0; i < delay; i++) begin
      tick;
      checks++;
      if (dav_ !== 1'b0 || a !== ta || b !== tb_ || res_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s drive_hold: dav_=%b a=%0d b=%0d rv=%b want 0 %0d %0d 0",
                 tag, dav_, a, b, res_valid, ta, tb_);
      end
    end
    pv  = consumer_result(ta, tb_);
    rfd = 1'b0;
    p   = pv;
    tick;
    exp_count++;
    exp_res_p = pv;
    checks++;
    if (res_valid !== 1'b1 || res_err !== 1'b0 || res_p !== exp_res_p || count !== exp_cnt() ||
        dav_ !== 1'b1) begin
      errors++;
      $display("FAIL %s result: rv=%b err=%b res_p=%0d count=%0d dav_=%b want 1 0 %0d %0d 1",
               tag, res_valid, res_err, res_p, count, dav_, exp_res_p, exp_cnt());
    end
    p = '0;
    for (int i = 0; i < hold; i++) begin
      tick;
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0 || res_valid !== 1'b0 || dav_ !== 1'b1 ||
          a !== ta || b !== tb_) begin
        errors++;
        $display("FAIL %s release_hold: busy=%b rdy=%b rv=%b dav_=%b a=%0d b=%0d want 1 0 0 1",
                 tag, busy, in_ready, res_valid, dav_, a, b);
      end
    end
    rfd = 1'b1;
    tick;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || dav_ !== 1'b1 || res_p !== exp_res_p) begin
      errors++;
      $display("FAIL %s back_idle: busy=%b rv=%b dav_=%b res_p=%0d want 0 0 1 %0d",
               tag, busy, res_valid, dav_, res_p, exp_res_p);
    end
  endtask

  task automatic test_reset;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    rfd      = 1'b1;
    p        = '0;
    exp_count = 0;
    exp_res_p = '0;
    tick;
    tick;
    checks++;
    if (dav_ !== 1'b1 || a !== '0 || b !== '0 || res_p !== '0 || res_valid !== 1'b0 ||
        res_err !== 1'b0 || count !== '0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: dav_=%b a=%0d b=%0d res_p=%0d rv=%b err=%b cnt=%0d busy=%b rdy=%b",
               dav_, a, b, res_p, res_valid, res_err, count, busy, in_ready);
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    run_txn(4'd3, 4'd5, 2, 0, 1'b0, 4'd0, 4'd0, "basic");
  endtask

  task automatic test_idle_rfd_low;
    rfd      = 1'b0;
    in_valid = 1'b1;
    in_a     = 4'd9;
    in_b     = 4'd2;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0 || dav_ !== 1'b1) begin
        errors++;
        $display("FAIL idle_rfd_low: rdy=%b busy=%b dav_=%b want 0 0 1", in_ready, busy, dav_);
      end
    end
    rfd = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_rfd_return: in_ready=%b want 1", in_ready);
    end
    in_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] pa [5];
    logic [W-1:0] pb [5];
    for (int i = 0; i < 5; i++) begin
      pa[i] = W'($urandom);
      pb[i] = W'($urandom);
    end
    for (int i = 0; i < 4; i++) begin
      run_txn(pa[i], pb[i], int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), i < 3,
              pa[i+1], pb[i+1], "b2b");
    end
  endtask

  task automatic test_timeout;
    int cycles;
    logic [W-1:0] ta;
    logic [W-1:0] tb_;
    ta       = W'($urandom);
    tb_      = W'($urandom);
    rfd      = 1'b1;
    in_valid = 1'b1;
    in_a     = ta;
    in_b     = tb_;
    tick;
    in_valid = 1'b0;
    tick;
    checks++;
    if (dav_ !== 1'b0) begin
      errors++;
      $display("FAIL timeout_dav_fall: dav_=%b want 0", dav_);
    end
    cycles = 0;
    while (cycles < int'(TIMEOUT) + 4) begin
      tick;
      cycles++;
      if (res_valid === 1'b1) break;
    end
    checks++;
    if (cycles !== int'(TIMEOUT) || res_valid !== 1'b1 || res_err !== 1'b1 || dav_ !== 1'b1 ||
        res_p !== exp_res_p || count !== exp_cnt()) begin
      errors++;
      $display("FAIL timeout_abort: cycles=%0d rv=%b err=%b dav_=%b res_p=%0d cnt=%0d want %0d 1 1 1 %0d %0d",
               cycles, res_valid, res_err, dav_, res_p, count, TIMEOUT, exp_res_p, exp_cnt());
    end
    tick;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || dav_ !== 1'b1) begin
      errors++;
      $display("FAIL timeout_release: rv=%b busy=%b dav_=%b want 0 0 1", res_valid, busy, dav_);
    end
  endtask

  task automatic test_slow_release;
    run_txn(W'($urandom), W'($urandom), 1, 10, 1'b0, 4'd0, 4'd0, "slow_release");
  endtask

  task automatic test_random;
    run_txn(W'($urandom), W'($urandom), int'(TIMEOUT) - 1, 0, 1'b0, 4'd0, 4'd0, "limit");
    for (int i = 0; i < 10; i++) begin
      run_txn(W'($urandom), W'($urandom), int'($urandom_range(0, TIMEOUT - 1)),
              int'($urandom_range(0, 4)), 1'b0, 4'd0, 4'd0, "random");
    end
  endtask

  task automatic test_reset_in_drive;
    rfd      = 1'b1;
    in_valid = 1'b1;
    in_a     = 4'd7;
    in_b     = 4'd6;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    #2;
    reset = 1'b1;
    #1;
    exp_count = 0;
    exp_res_p = '0;
    checks++;
    if (dav_ !== 1'b1 || busy !== 1'b0 || a !== '0 || b !== '0 || res_p !== '0 ||
        count !== '0 || res_valid !== 1'b0 || res_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_drive: dav_=%b busy=%b a=%0d b=%0d res_p=%0d cnt=%0d rv=%b err=%b",
               dav_, busy, a, b, res_p, count, res_valid, res_err);
    end
    tick;
    reset = 1'b0;
    tick;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || dav_ !== 1'b1) begin
      errors++;
      $display("FAIL reset_after: rv=%b busy=%b dav_=%b want 0 0 1", res_valid, busy, dav_);
    end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 5; i++) begin
      run_txn(W'($urandom), W'($urandom), int'($urandom_range(0, 3)), 0, 1'b0, 4'd0, 4'd0,
              "wrap");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_idle_rfd_low();
    test_back_to_back();
    test_timeout();
    test_slow_release();
    test_random();
    test_reset_in_drive();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
